spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI mode-0 target (CPOL=0, CPHA=0), MSB first, for the far end of the team's SPI master bus.
- Oversamples the external sclk/ss_n/mosi with the system clock. Receives DATA_W-bit words into a parallel output and shifts out pre-loaded parallel data on miso.
- Supports multi-word bursts while ss_n stays low.
- Sits between the SPI pins and a local register/control block.

Parameters:
- DATA_W, 8, word width in bits.
- SYNC_STAGES, 2, flip-flop stages on each of sclk, ss_n and mosi (minimum 2).
- DEFAULT_TX, 8'hFF, word sent when no tx word is pending at word start.

Ports:
- clk  input  1  system clock; must run at least 4x sclk.
- reset  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI serial clock, asynchronous to clk.
- ss_n  input  1  slave select, active-low, asynchronous.
- mosi  input  1  serial data in.
- miso  output  1  serial data out.
- miso_oe  output  1  output enable for the pad; high while selected.
- tx_data  input  DATA_W  word to transmit.
- tx_load  input  1  write strobe for tx_data.
- tx_ready  output  1  tx holding buffer empty.
- rx_data  output  DATA_W  last complete received word.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- busy  output  1  high while ss_n is (synchronised) low.

Behaviour:
- Reset (reset=0, async) forces: state IDLE, miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, bit counter=0.
- Synchronisers:
  - sclk, ss_n and mosi each pass through SYNC_STAGES flops.
  - Edge detectors on synchronised sclk produce one-clk pulses: rise_p and fall_p.
  - ss_n falling/rising is detected the same way.
- TX holding buffer:
  - tx_load while tx_ready=1 captures tx_data and clears tx_ready the next clk.
  - tx_load while tx_ready=0 is ignored; the buffer is unchanged.
  - The buffer is consumed at each word start, setting tx_ready=1.
  - If the buffer is empty at word start, DEFAULT_TX is sent.
  - tx_load coinciding with a consume: the consume takes the old contents, then the new word is captured.
- State machine, 2 states:
  - IDLE: miso_oe=0, busy=0. On synchronised ss_n falling: load tx_shift from buffer/DEFAULT_TX, drive miso=tx_shift MSB, clear bit counter, go to SHIFT.
  - SHIFT: miso_oe=1, busy=1.
    - rise_p: rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}, then counter+1.
    - Counter reaching DATA_W on a rise_p: counter wraps to 0. On the following clk, rx_data <= rx_shift and rx_valid pulses for one clk.
    - fall_p with counter != 0: shift tx_shift left; miso = new MSB.
    - fall_p with counter == 0 (word boundary): reload tx_shift from buffer/DEFAULT_TX (consume) and drive its MSB.
    - Synchronised ss_n rising: go to IDLE. A partial word (counter != 0) is discarded with no rx_valid, and rx_data is unchanged.
- Latency: rx_valid asserts SYNC_STAGES+2 clk after the raw sclk rising edge of the last bit.
- Simultaneous ss_n rise and final rise_p in the same clk: the word completes and rx_valid pulses, then IDLE.
- rx_data holds its value until the next complete word. There is no back-pressure; the consumer must take the word within DATA_W sclk periods.
- Reset mid-transfer aborts immediately with all outputs at reset values. The slave re-arms only on a fresh ss_n falling edge.

Optional Feature:
- Macro: SPI_SLAVE_UNDERRUN_FLAG_EN.
- Defined:
  - Adds output port tx_underrun (1 bit), a sticky flag.
  - Set when a word start (ss_n fall or word boundary) finds the tx buffer empty.
  - Cleared by an accepted tx_load; reset value 0.
  - Set and clear in the same clk: set wins.
- Undefined: the port and its logic are absent, and DEFAULT_TX is sent silently.

Decomposition:
- Package spi_pkg holds:
  - State encoding typedef: IDLE=1'b0, SHIFT=1'b1.
  - Constants SPI_SYNC_MIN=2 and SPI_DEFAULT_TX=8'hFF, shared with the master.
- One sub-module: spi_sync_edge. It takes a 1-bit async input and outputs the synchronised level plus rise/fall pulses, parameterised by SYNC_STAGES. It is instantiated for sclk and ss_n; mosi uses the level output only.

Test Plan:
- Single word: tx_load 8'hA5, ss_n low, 8 sclk at clk/8 with mosi 8'h3C, then ss_n high -> miso bits 1,0,1,0,0,1,0,1; one rx_valid with rx_data=8'h3C; tx_ready=1 after word start.
- Burst: load 8'h11; after first word start load 8'h22; 16 sclk with mosi 8'h81,8'h7E -> miso 8'h11 then 8'h22; rx_valid twice with 8'h81 then 8'h7E.
- Underrun: no tx_load, 8 sclk -> miso=8'hFF; with SPI_SLAVE_UNDERRUN_FLAG_EN, tx_underrun=1 until the next tx_load.
- Abort: ss_n high after 5 sclk -> no rx_valid, rx_data keeps its previous value, state IDLE, miso_oe=0.
- Reset mid-word: reset=0 after 3 sclk -> all outputs at reset values within 1 clk. A new ss_n frame with mosi 8'hC3 gives rx_data=8'hC3.
- Load collision: tx_load while tx_ready=0 -> ignored; the previously loaded word is the one transmitted.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI definitions: FSM state encoding and constants common to master and slave
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

    localparam int         SPI_SYNC_MIN   = 2;
    localparam logic [7:0] SPI_DEFAULT_TX = 8'hFF;

endpackage

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pin and local tx/rx bundle between the slave and its master/register side
// Signals: sclk, ss_n, mosi (pins in), miso, miso_oe (pins out), tx_data/tx_load/tx_ready (tx holding buffer),
//          rx_data/rx_valid (received words), busy; tx_underrun when SPI_SLAVE_UNDERRUN_FLAG_EN is defined.
// Modports: slave (the spi_slave), master (SPI master pins plus the local register block).
interface spi_slave_if #(
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              ss_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
    logic              tx_underrun;

    modport slave (
        input  sclk, ss_n, mosi, tx_data, tx_load,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun
    );

    modport master (
        output sclk, ss_n, mosi, tx_data, tx_load,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun
    );
`else
    modport slave (
        input  sclk, ss_n, mosi, tx_data, tx_load,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, busy
    );

    modport master (
        output sclk, ss_n, mosi, tx_data, tx_load,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy
    );
`endif
endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with one-clk rise/fall pulses for an asynchronous 1-bit input
// Ports: clk, reset (async, active-low), i_async (raw input), o_level (synchronised level),
//        o_rise / o_fall (one-clk pulses on synchronised edges).
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    // Edges are suppressed until the chain holds real samples, so a pin
    // that differs from RESET_VAL after reset does not fake an edge.
    logic [SYNC_STAGES:0]   r_primed;
    logic                   w_primed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync   <= {SYNC_STAGES{RESET_VAL}};
            r_prev   <= RESET_VAL;
            r_primed <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev   <= r_sync[SYNC_STAGES-1];
            r_primed <= {r_primed[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_primed = r_primed[SYNC_STAGES];
    assign o_level  = r_sync[SYNC_STAGES-1];
    assign o_rise   = w_primed &  o_level & ~r_prev;
    assign o_fall   = w_primed & ~o_level &  r_prev;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 slave, MSB first, oversampled by clk, with tx holding buffer and burst support
// Ports: clk, reset (async, active-low), bus (spi_slave_if.slave: pins, tx buffer, rx word, busy).
// Optional: SPI_SLAVE_UNDERRUN_FLAG_EN adds sticky bus.tx_underrun.
module spi_slave
    import spi_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = SPI_SYNC_MIN,
    parameter logic [DATA_W-1:0] DEFAULT_TX  = DATA_W'(SPI_DEFAULT_TX)
) (
    input  logic       clk,
    input  logic       reset,
    spi_slave_if.slave bus
);

    localparam int STAGES = (SYNC_STAGES < SPI_SYNC_MIN) ? SPI_SYNC_MIN : SYNC_STAGES;
    localparam int CNT_W  = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_ss_level, w_ss_rise, w_ss_fall;
    logic w_unused_levels;

    spi_sync_edge #(.SYNC_STAGES(STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk     (clk),
        .reset   (reset),
        .i_async (bus.sclk),
        .o_level (w_sclk_level),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk     (clk),
        .reset   (reset),
        .i_async (bus.ss_n),
        .o_level (w_ss_level),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    assign w_unused_levels = w_sclk_level | w_ss_level;

    // mosi shares the sclk delay so its level lines up with rise pulses.
    logic [STAGES-1:0] r_mosi_sync;
    logic              w_mosi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_mosi_sync <= '0;
        else        r_mosi_sync <= {r_mosi_sync[STAGES-2:0], bus.mosi};
    end

    assign w_mosi = r_mosi_sync[STAGES-1];

    spi_state_t        r_state, w_state_next;
    logic [DATA_W-1:0] r_tx_buf;
    logic              r_tx_ready;
    logic [DATA_W-1:0] r_tx_shift;
    logic [DATA_W-1:0] r_rx_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_word_done;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;

    logic              w_frame_start;
    logic              w_consume;
    logic              w_tx_shift_en;
    logic              w_rx_shift_en;
    logic              w_miso, w_miso_oe, w_busy;
    logic              w_tx_accept;
    logic [DATA_W-1:0] w_tx_word;

    assign w_tx_accept = bus.tx_load & r_tx_ready;
    assign w_tx_word   = r_tx_ready ? DEFAULT_TX : r_tx_buf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_frame_start = 1'b0;
        w_consume     = 1'b0;
        w_tx_shift_en = 1'b0;
        w_rx_shift_en = 1'b0;
        w_miso        = 1'b0;
        w_miso_oe     = 1'b0;
        w_busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ss_fall) begin
                    w_frame_start = 1'b1;
                    w_consume     = 1'b1;
                    w_state_next  = SHIFT;
                end
            end
            SHIFT: begin
                w_miso        = r_tx_shift[DATA_W-1];
                w_miso_oe     = 1'b1;
                w_busy        = 1'b1;
                // A last rise coinciding with deselect still completes the word.
                w_rx_shift_en = w_sclk_rise;
                if (w_sclk_fall) begin
                    if (r_bit_cnt == '0) w_consume     = 1'b1;
                    else                 w_tx_shift_en = 1'b1;
                end
                if (w_ss_rise) begin
                    w_consume     = 1'b0;
                    w_tx_shift_en = 1'b0;
                    w_state_next  = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Holding buffer: a consume empties it first, so a same-clk load lands
    // after the old word has been taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_buf   <= '0;
            r_tx_ready <= 1'b1;
        end else begin
            if (w_consume) r_tx_ready <= 1'b1;
            if (w_tx_accept) begin
                r_tx_buf   <= bus.tx_data;
                r_tx_ready <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_bit_cnt   <= '0;
            r_word_done <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
        end else begin
            if (w_consume)          r_tx_shift <= w_tx_word;
            else if (w_tx_shift_en) r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};

            if (w_frame_start) begin
                r_bit_cnt <= '0;
            end else if (w_rx_shift_en) begin
                r_rx_shift <= {r_rx_shift[DATA_W-2:0], w_mosi};
                r_bit_cnt  <= (r_bit_cnt == CNT_LAST) ? '0 : r_bit_cnt + 1'b1;
            end

            r_word_done <= w_rx_shift_en && (r_bit_cnt == CNT_LAST);
            r_rx_valid  <= r_word_done;
            if (r_word_done) r_rx_data <= r_rx_shift;
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
    logic r_tx_underrun;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                       r_tx_underrun <= 1'b0;
        else if (w_consume && r_tx_ready) r_tx_underrun <= 1'b1;
        else if (w_tx_accept)             r_tx_underrun <= 1'b0;
    end

    assign bus.tx_underrun = r_tx_underrun;
`endif

    assign bus.miso     = w_miso;
    assign bus.miso_oe  = w_miso_oe;
    assign bus.busy     = w_busy;
    assign bus.tx_ready = r_tx_ready;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard bench for spi_slave: directed frames, miso/rx monitors, boundary checks
module tb_spi_slave;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    spi_slave_if #(.DATA_W(8)) bus ();

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic       exp_miso[$];
    logic [7:0] exp_rx[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge bus.sclk) begin
        if (exp_miso.size() > 0) begin
            logic e;
            e = exp_miso.pop_front();
            chk("miso_bit", bus.miso, e);
        end
    end

    always @(negedge clk) begin
        if (reset && bus.rx_valid) begin
            if (exp_rx.size() == 0) begin
                chk("rx_valid_unexpected", bus.rx_valid, 1'b0);
            end else begin
                logic [7:0] e;
                e = exp_rx.pop_front();
                chk("rx_data", bus.rx_data, e);
            end
        end
    end

    task automatic push_tx(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) exp_miso.push_back(w[7-i]);
    endtask

    task automatic load(input logic [7:0] d);
        @(negedge clk);
        bus.tx_data = d;
        bus.tx_load = 1'b1;
        @(negedge clk);
        bus.tx_load = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        bus.ss_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic end_frame();
        repeat (4) @(negedge clk);
        bus.ss_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_bits(input logic [7:0] w, input int nbits, input bit lat_chk);
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = w[7-i];
            repeat (4) @(negedge clk);
            bus.sclk = 1'b1;
            if (lat_chk && i == 7) begin
                repeat (3) @(posedge clk);
                #1 chk("rx_valid_early", bus.rx_valid, 1'b0);
                @(posedge clk);
                #1 chk("rx_valid_latency", bus.rx_valid, 1'b1);
                @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            bus.sclk = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sclk = 1'b0; bus.ss_n = 1'b1; bus.mosi = 1'b0;
        bus.tx_data = '0; bus.tx_load = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_miso", bus.miso, 1'b0);
        chk("rst_miso_oe", bus.miso_oe, 1'b0);
        chk("rst_tx_ready", bus.tx_ready, 1'b1);
        chk("rst_rx_data", bus.rx_data, 8'h00);
        chk("rst_rx_valid", bus.rx_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Single word
        load(8'hA5);
        chk("single_tx_ready_loaded", bus.tx_ready, 1'b0);
        push_tx(8'hA5, 8);
        exp_rx.push_back(8'h3C);
        start_frame();
        chk("single_tx_ready_consumed", bus.tx_ready, 1'b1);
        chk("single_busy", bus.busy, 1'b1);
        chk("single_miso_oe", bus.miso_oe, 1'b1);
        frame_bits(8'h3C, 8, 1'b1);
        end_frame();
        chk("single_idle_busy", bus.busy, 1'b0);

        // Burst of two words
        load(8'h11);
        push_tx(8'h11, 8);
        push_tx(8'h22, 8);
        exp_rx.push_back(8'h81);
        exp_rx.push_back(8'h7E);
        start_frame();
        load(8'h22);
        chk("burst_tx_ready_second", bus.tx_ready, 1'b0);
        frame_bits(8'h81, 8, 1'b0);
        frame_bits(8'h7E, 8, 1'b0);
        end_frame();

        // Underrun: nothing loaded, default word goes out
        push_tx(8'hFF, 8);
        exp_rx.push_back(8'h5A);
        start_frame();
        frame_bits(8'h5A, 8, 1'b0);
        end_frame();
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
        chk("underrun_set", bus.tx_underrun, 1'b1);
`endif

        // Abort after 5 bits
        push_tx(8'hFF, 5);
        start_frame();
        frame_bits(8'hE7, 5, 1'b0);
        end_frame();
        chk("abort_rx_data_kept", bus.rx_data, 8'h5A);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_miso_oe", bus.miso_oe, 1'b0);
        chk("abort_miso", bus.miso, 1'b0);

        // Reset mid-word, no re-arm while ss_n stays low
        load(8'h96);
        push_tx(8'h96, 3);
        start_frame();
        frame_bits(8'hAA, 3, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_miso", bus.miso, 1'b0);
        chk("midrst_miso_oe", bus.miso_oe, 1'b0);
        chk("midrst_tx_ready", bus.tx_ready, 1'b1);
        chk("midrst_rx_data", bus.rx_data, 8'h00);
        chk("midrst_rx_valid", bus.rx_valid, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_no_rearm", bus.busy, 1'b0);
        bus.ss_n = 1'b1;
        repeat (8) @(negedge clk);
        push_tx(8'hFF, 8);
        exp_rx.push_back(8'hC3);
        start_frame();
        frame_bits(8'hC3, 8, 1'b0);
        end_frame();
        chk("post_rst_rx_data", bus.rx_data, 8'hC3);

        // Load collision: second load ignored
        load(8'h3A);
        chk("coll_tx_ready_first", bus.tx_ready, 1'b0);
        load(8'hC5);
        chk("coll_tx_ready_second", bus.tx_ready, 1'b0);
        push_tx(8'h3A, 8);
        exp_rx.push_back(8'h0F);
        start_frame();
        chk("coll_tx_ready_consumed", bus.tx_ready, 1'b1);
        frame_bits(8'h0F, 8, 1'b0);
        end_frame();

`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
        chk("underrun_sticky", bus.tx_underrun, 1'b1);
        load(8'h55);
        chk("underrun_cleared", bus.tx_underrun, 1'b0);
`endif

        repeat (20) @(negedge clk);
        chk("rx_queue_drained", exp_rx.size(), 0);
        chk("miso_queue_drained", exp_miso.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
